vga_timing: RTL and testbench

//  Upstream stage of the game renderer: free-running 640x480@60Hz raster generator on clk25.

---
 rtl/vga_timing.sv | 95 +++++++++
 tb/tb_vga_timing.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/vga_timing.sv
// 640x480@60Hz raster generator: free-running pixel/line counters plus a one-cycle
// registered output stage that blanks the game colour and aligns it with hsync/vsync.
module vga_timing #(
    parameter int   H_VISIBLE = 640,
    parameter int   H_FRONT   = 16,
    parameter int   H_SYNC    = 96,
    parameter int   H_BACK    = 48,
    parameter int   V_VISIBLE = 480,
    parameter int   V_FRONT   = 10,
    parameter int   V_SYNC    = 2,
    parameter int   V_BACK    = 33,
    parameter logic SYNC_POL  = 1'b0
) (
    input  logic       clk25,
    input  logic       Reset,
    output logic [9:0] xpos,
    output logic [9:0] ypos,
    output logic       frame_start,
    input  logic [2:0] red_in,
    input  logic [2:0] green_in,
    input  logic [1:0] blue_in,
    output logic [2:0] vga_red,
    output logic [2:0] vga_green,
    output logic [1:0] vga_blue,
    output logic       hsync,
    output logic       vsync
);

    localparam logic [9:0] H_VIS_END = 10'(H_VISIBLE);
    localparam logic [9:0] H_SYNC_ST = 10'(H_VISIBLE + H_FRONT);
    localparam logic [9:0] H_SYNC_EN = 10'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [9:0] H_LAST    = 10'(H_VISIBLE + H_FRONT + H_SYNC + H_BACK - 1);
    localparam logic [9:0] V_VIS_END = 10'(V_VISIBLE);
    localparam logic [9:0] V_SYNC_ST = 10'(V_VISIBLE + V_FRONT);
    localparam logic [9:0] V_SYNC_EN = 10'(V_VISIBLE + V_FRONT + V_SYNC);
    localparam logic [9:0] V_LAST    = 10'(V_VISIBLE + V_FRONT + V_SYNC + V_BACK - 1);

    logic [9:0] r_x;
    logic [9:0] r_y;
    logic [2:0] r_red;
    logic [2:0] r_green;
    logic [1:0] r_blue;
    logic       r_hsync;
    logic       r_vsync;

    logic       w_visible;
    logic       w_hsync_next;
    logic       w_vsync_next;

    // Raster counters: x wraps every line, y advances only on the last pixel of a line.
    always_ff @(posedge clk25) begin
        if (Reset) begin
            r_x <= 10'd0;
            r_y <= 10'd0;
        end else if (r_x == H_LAST) begin
            r_x <= 10'd0;
            r_y <= (r_y == V_LAST) ? 10'd0 : r_y + 10'd1;
        end else begin
            r_x <= r_x + 10'd1;
        end
    end

    always_comb begin
        w_visible    = (r_x < H_VIS_END) && (r_y < V_VIS_END);
        w_hsync_next = ((r_x >= H_SYNC_ST) && (r_x < H_SYNC_EN)) ? SYNC_POL : ~SYNC_POL;
        w_vsync_next = ((r_y >= V_SYNC_ST) && (r_y < V_SYNC_EN)) ? SYNC_POL : ~SYNC_POL;
    end

    // Output stage: colour and sync for counter value N leave together one clock later.
    always_ff @(posedge clk25) begin
        if (Reset) begin
            r_red   <= 3'd0;
            r_green <= 3'd0;
            r_blue  <= 2'd0;
            r_hsync <= ~SYNC_POL;
            r_vsync <= ~SYNC_POL;
        end else begin
            r_red   <= w_visible ? red_in   : 3'd0;
            r_green <= w_visible ? green_in : 3'd0;
            r_blue  <= w_visible ? blue_in  : 2'd0;
            r_hsync <= w_hsync_next;
            r_vsync <= w_vsync_next;
        end
    end

    assign xpos        = r_x;
    assign ypos        = r_y;
    assign frame_start = (r_x == 10'd0) && (r_y == 10'd0) && !Reset;
    assign vga_red     = r_red;
    assign vga_green   = r_green;
    assign vga_blue    = r_blue;
    assign hsync       = r_hsync;
    assign vsync       = r_vsync;

endmodule

// File: tb/tb_vga_timing.sv
// Bench for vga_timing: a full-size instance for horizontal timing and a short-frame
// instance (13 lines) so vertical sync and frame wrap are reached in a few thousand clocks.
module tb_vga_timing;

    logic       clk25 = 1'b0;
    logic       Reset;
    logic [2:0] red_in;
    logic [2:0] green_in;
    logic [1:0] blue_in;

    logic [9:0] xpos_a, ypos_a, xpos_b, ypos_b;
    logic       fs_a, fs_b, hs_a, hs_b, vs_a, vs_b;
    logic [2:0] red_a, red_b, green_a, green_b;
    logic [1:0] blue_a, blue_b;

    int checks = 0;
    int errors = 0;

    always #5 clk25 = ~clk25;

    vga_timing dut_a (
        .clk25(clk25), .Reset(Reset), .xpos(xpos_a), .ypos(ypos_a), .frame_start(fs_a),
        .red_in(red_in), .green_in(green_in), .blue_in(blue_in),
        .vga_red(red_a), .vga_green(green_a), .vga_blue(blue_a), .hsync(hs_a), .vsync(vs_a)
    );

    vga_timing #(.V_VISIBLE(6), .V_FRONT(2), .V_SYNC(2), .V_BACK(3)) dut_b (
        .clk25(clk25), .Reset(Reset), .xpos(xpos_b), .ypos(ypos_b), .frame_start(fs_b),
        .red_in(red_in), .green_in(green_in), .blue_in(blue_in),
        .vga_red(red_b), .vga_green(green_b), .vga_blue(blue_b), .hsync(hs_b), .vsync(vs_b)
    );

    typedef struct {
        int sel;
        int x;
        int y;
        int red;
        int exp_red;
        int exp_hs;
        int exp_vs;
        int exp_x;
        int exp_y;
        int exp_fs;
    } vec_t;

    vec_t vecs[$];

    task automatic step();
        @(posedge clk25);
        #1;
    endtask

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic drive_colour(input int r);
        red_in   = 3'(r);
        green_in = 3'(r);
        blue_in  = 2'(r);
    endtask

    task automatic get_pos(input int sel, output int x, output int y);
        x = (sel == 0) ? int'(xpos_a) : int'(xpos_b);
        y = (sel == 0) ? int'(ypos_a) : int'(ypos_b);
    endtask

    task automatic wait_pos(input int sel, input int x, input int y, input string name);
        int cx, cy, n;
        n = 0;
        get_pos(sel, cx, cy);
        while (!(cx == x && cy == y) && n < 12000) begin
            step();
            n++;
            get_pos(sel, cx, cy);
        end
        if (n >= 12000) begin
            checks++;
            errors++;
            $display("FAIL %s timeout: got %0d,%0d expected %0d,%0d", name, cx, cy, x, y);
        end
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, " xa"}, int'(xpos_a), 0);
        check({tag, " ya"}, int'(ypos_a), 0);
        check({tag, " xb"}, int'(xpos_b), 0);
        check({tag, " yb"}, int'(ypos_b), 0);
        check({tag, " hs"}, int'(hs_a), 1);
        check({tag, " vs"}, int'(vs_a), 1);
        check({tag, " red"}, int'(red_a), 0);
        check({tag, " green"}, int'(green_a), 0);
        check({tag, " blue"}, int'(blue_a), 0);
        check({tag, " fs_a"}, int'(fs_a), 0);
        check({tag, " fs_b"}, int'(fs_b), 0);
    endtask

    initial begin
        int r, g, b, hs, vs, fs, x, y, lows, prev, n;
        string nm;

        vecs.push_back('{0,   5, 0, 5, 5, 1, 1,   6,  0, 0});
        vecs.push_back('{0, 639, 0, 7, 7, 1, 1, 640,  0, 0});
        vecs.push_back('{0, 640, 0, 7, 0, 1, 1, 641,  0, 0});
        vecs.push_back('{0, 655, 0, 7, 0, 1, 1, 656,  0, 0});
        vecs.push_back('{0, 656, 0, 7, 0, 0, 1, 657,  0, 0});
        vecs.push_back('{0, 751, 0, 7, 0, 0, 1, 752,  0, 0});
        vecs.push_back('{0, 752, 0, 7, 0, 1, 1, 753,  0, 0});
        vecs.push_back('{0, 799, 0, 7, 0, 1, 1,   0,  1, 0});
        vecs.push_back('{0,   0, 1, 3, 3, 1, 1,   1,  1, 0});
        vecs.push_back('{0,   1, 1, 6, 6, 1, 1,   2,  1, 0});
        vecs.push_back('{0, 639, 1, 2, 2, 1, 1, 640,  1, 0});
        vecs.push_back('{0, 799, 5, 7, 0, 1, 1,   0,  6, 0});
        vecs.push_back('{1,   5, 6, 7, 0, 1, 1,   6,  6, 0});
        vecs.push_back('{1, 799, 7, 7, 0, 1, 1,   0,  8, 0});
        vecs.push_back('{1,   0, 8, 7, 0, 1, 0,   1,  8, 0});
        vecs.push_back('{1, 799, 9, 7, 0, 1, 0,   0, 10, 0});
        vecs.push_back('{1,   0,10, 7, 0, 1, 1,   1, 10, 0});
        vecs.push_back('{1, 799,12, 7, 0, 1, 1,   0,  0, 1});
        vecs.push_back('{1,   0, 0, 7, 7, 1, 1,   1,  0, 0});
        vecs.push_back('{1, 639, 5, 7, 7, 1, 1, 640,  5, 0});
        vecs.push_back('{1, 640, 5, 7, 0, 1, 1, 641,  5, 0});

        // Power-up reset with a bright colour applied: outputs must stay blanked.
        Reset = 1'b1;
        drive_colour(7);
        repeat (3) step();
        check_reset_state("init reset");
        Reset = 1'b0;
        #1;
        check("init release fs_a", int'(fs_a), 1);
        check("init release fs_b", int'(fs_b), 1);

        for (int i = 0; i < vecs.size(); i++) begin
            nm = $sformatf("vec%0d", i);
            wait_pos(vecs[i].sel, vecs[i].x, vecs[i].y, nm);
            drive_colour(vecs[i].red);
            step();
            get_pos(vecs[i].sel, x, y);
            r  = (vecs[i].sel == 0) ? int'(red_a)   : int'(red_b);
            g  = (vecs[i].sel == 0) ? int'(green_a) : int'(green_b);
            b  = (vecs[i].sel == 0) ? int'(blue_a)  : int'(blue_b);
            hs = (vecs[i].sel == 0) ? int'(hs_a)    : int'(hs_b);
            vs = (vecs[i].sel == 0) ? int'(vs_a)    : int'(vs_b);
            fs = (vecs[i].sel == 0) ? int'(fs_a)    : int'(fs_b);
            check({nm, " red"}, r, vecs[i].exp_red);
            check({nm, " green"}, g, vecs[i].exp_red);
            check({nm, " blue"}, b, vecs[i].exp_red & 3);
            check({nm, " hsync"}, hs, vecs[i].exp_hs);
            check({nm, " vsync"}, vs, vecs[i].exp_vs);
            check({nm, " xpos"}, x, vecs[i].exp_x);
            check({nm, " ypos"}, y, vecs[i].exp_y);
            check({nm, " frame_start"}, fs, vecs[i].exp_fs);
        end

        // One full line on the full-size instance: exactly 96 hsync-low clocks.
        get_pos(0, x, y);
        wait_pos(0, 0, (y + 1) % 525, "line start");
        lows = 0;
        for (int i = 0; i < 800; i++) begin
            step();
            if (hs_a == 1'b0) lows++;
        end
        check("hsync low count", lows, 96);

        // Colour follows xpos[2:0] with one clock of latency.
        drive_colour(7);
        get_pos(0, x, y);
        wait_pos(0, 0, (y + 1) % 525, "align start");
        for (int i = 0; i < 16; i++) begin
            prev = int'(xpos_a[2:0]);
            drive_colour(prev);
            step();
            check($sformatf("align%0d red", i), int'(red_a), prev);
        end

        // Short-frame instance: frame_start period and vsync low count over one frame.
        drive_colour(7);
        n = 0;
        while (fs_b !== 1'b1 && n < 12000) begin
            step();
            n++;
        end
        check("frame_start seen", int'(fs_b), 1);
        lows = 0;
        n = 0;
        do begin
            step();
            n++;
            if (vs_b == 1'b0) lows++;
        end while (fs_b !== 1'b1 && n < 12000);
        check("frame period", n, 10400);
        check("vsync low count", lows, 1600);

        // Mid-frame reset on the full-size instance, then release.
        wait_pos(0, 300, int'(ypos_a), "mid reset pos");
        Reset = 1'b1;
        repeat (3) step();
        check_reset_state("mid reset");
        Reset = 1'b0;
        #1;
        check("mid release fs_a", int'(fs_a), 1);
        step();
        check("mid release xa", int'(xpos_a), 1);
        check("mid release ya", int'(ypos_a), 0);
        check("mid release fs_a low", int'(fs_a), 0);
        check("mid release red", int'(red_a), 7);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
